// File: rtl/if_fetch_pkg.sv
// Shared CPU definitions used by the instruction-fetch stage.
package if_fetch_pkg;

    typedef enum logic {
        ISSUE    = 1'b0,
        WAIT_RSP = 1'b1
    } if_state_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
    localparam int          PC_STEP   = 4;

endpackage

// File: rtl/pc_reg.sv
// Load-enabled register with asynchronous active-low reset to a parameterised value.
module pc_reg #(
    parameter int             W         = 32,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: one outstanding imem request, single-entry output slot
// towards decode, redirect flushes the slot and discards any in-flight response.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [31:0]       id_instr,
    input  logic              id_ready
);

    if_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pc_en;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              discard_q, discard_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [31:0]       id_instr_q, id_instr_d;

    logic              slot_free;
    logic              fire;
    logic [ADDR_W-1:0] target_pc;

    pc_reg #(
        .W         (ADDR_W),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .en  (pc_en),
        .d   (pc_d),
        .q   (pc_q)
    );

    assign target_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign slot_free = !id_valid_q || id_ready;
    // Gated by rst so no request leaks out while the stage is held in reset.
    assign imem_req  = rst && (state_q == ISSUE) && slot_free;
    assign fire      = imem_req && imem_gnt;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_en      = 1'b0;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;

        if (id_valid_q && id_ready) begin
            id_valid_d = 1'b0;
        end

        unique case (state_q)
            ISSUE: begin
                if (fire) begin
                    state_d  = WAIT_RSP;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + ADDR_W'(PC_STEP);
                    pc_en    = 1'b1;
                end
            end
            WAIT_RSP: begin
                if (imem_rvalid) begin
                    state_d   = ISSUE;
                    discard_d = 1'b0;
                    if (!discard_q && !redirect_valid) begin
                        id_valid_d = 1'b1;
                        id_pc_d    = req_pc_q;
                        id_instr_d = imem_rdata;
                    end
                end
            end
            default: state_d = ISSUE;
        endcase

        // A response still owed after the redirect belongs to the old path.
        if (redirect_valid) begin
            pc_d       = target_pc;
            pc_en      = 1'b1;
            id_valid_d = 1'b0;
            if (state_q == WAIT_RSP) begin
                discard_d = !imem_rvalid;
            end else if (fire) begin
                discard_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ISSUE;
            req_pc_q   <= '0;
            discard_q  <= 1'b0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= INSTR_NOP;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
        end
    end

    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_instr  = id_instr_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: scoreboard of expected PCs, memory stubs, two instances
// (RESET_PC = 0 and RESET_PC = FFFF_FFF8).
module tb_if_fetch;

    localparam logic [31:0] DATA_KEY = 32'hC0DE_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: RESET_PC = 0
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready;

    if_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut_a (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_ready       (id_ready)
    );

    // Instance B: wrap-around start address
    logic        b_redirect_valid = 1'b0;
    logic [31:0] b_redirect_pc = 32'h0;
    logic        b_req;
    logic [31:0] b_addr;
    logic        b_gnt;
    logic        b_rvalid;
    logic [31:0] b_rdata;
    logic        b_id_valid;
    logic [31:0] b_id_pc;
    logic [31:0] b_id_instr;
    logic        b_id_ready = 1'b1;

    if_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (b_redirect_valid),
        .redirect_pc    (b_redirect_pc),
        .imem_req       (b_req),
        .imem_addr      (b_addr),
        .imem_gnt       (b_gnt),
        .imem_rvalid    (b_rvalid),
        .imem_rdata     (b_rdata),
        .id_valid       (b_id_valid),
        .id_pc          (b_id_pc),
        .id_instr       (b_id_instr),
        .id_ready       (b_id_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Memory stub A: latency 1 or 2 cycles after the grant cycle
    int          lat_a = 1;
    logic        v1 = 1'b0, v2 = 1'b0;
    logic [31:0] a1 = '0, a2 = '0;
    always @(posedge clk) begin
        v1 <= imem_req && imem_gnt;
        a1 <= imem_addr;
        v2 <= v1;
        a2 <= a1;
    end
    assign imem_rvalid = (lat_a == 1) ? v1 : v2;
    assign imem_rdata  = ((lat_a == 1) ? a1 : a2) ^ DATA_KEY;

    // Memory stub B: grants the first three requests only, latency 1
    int          b_cnt = 0;
    logic        bv = 1'b0;
    logic [31:0] ba = '0;
    logic [31:0] b_tab [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    assign b_gnt    = b_req && (b_cnt < 3);
    assign b_rvalid = bv;
    assign b_rdata  = ba ^ DATA_KEY;
    always @(posedge clk) begin
        bv <= b_req && b_gnt;
        ba <= b_addr;
        if (b_req && b_gnt) b_cnt <= b_cnt + 1;
    end
    always @(negedge clk) begin
        if (rst === 1'b1 && b_req && b_gnt) check("b_addr", b_addr, b_tab[b_cnt]);
    end

    // Scoreboards: expected PCs in transfer order
    logic [31:0] exp_q [$];
    logic [31:0] exp_qb [$];
    logic [31:0] e_a, e_b;

    always @(negedge clk) begin
        if (rst === 1'b1 && id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected: got pc %08h expected none", id_pc);
            end else begin
                e_a = exp_q.pop_front();
                $display("a transfer pc=%08h instr=%08h", id_pc, id_instr);
                check("a_pc", id_pc, e_a);
                check("a_instr", id_instr, e_a ^ DATA_KEY);
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && b_id_valid && b_id_ready) begin
            if (exp_qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected: got pc %08h expected none", b_id_pc);
            end else begin
                e_b = exp_qb.pop_front();
                $display("b transfer pc=%08h instr=%08h", b_id_pc, b_id_instr);
                check("b_pc", b_id_pc, e_b);
                check("b_instr", b_id_instr, e_b ^ DATA_KEY);
            end
        end
    end

    // Waits (bounded) for a request; checks cycles waited when exp_cnt > 0
    task automatic wait_req(input string name, input logic [31:0] exp_addr, input int exp_cnt);
        int cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!imem_req && cnt < 20);
        if (exp_cnt > 0) check({name, "_lat"}, 32'(cnt), 32'(exp_cnt));
        check({name, "_req"}, {31'b0, imem_req}, 32'h1);
        check({name, "_addr"}, imem_addr, exp_addr);
    endtask

    task automatic grant(input string name, input logic [31:0] exp_addr, input int exp_cnt);
        wait_req(name, exp_addr, exp_cnt);
        imem_gnt = 1'b1;
        @(posedge clk);
        #1 imem_gnt = 1'b0;
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst            = 1'b0;
        imem_gnt       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, id_valid}, 32'h0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_instr", id_instr, 32'h0);
        check("rst_b_addr", b_addr, 32'hFFFF_FFF8);
        check("rst_b_req", {31'b0, b_req}, 32'h0);

        // Back-to-back fetch, one instruction every 2 cycles
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        exp_qb.push_back(32'hFFFF_FFF8); exp_qb.push_back(32'hFFFF_FFFC); exp_qb.push_back(32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        grant("t1_a0", 32'h0, 1);
        grant("t1_a4", 32'h4, 2);
        grant("t1_a8", 32'h8, 2);
        repeat (3) @(negedge clk);
        check("t1_drain", 32'(exp_q.size()), 32'h0);

        // Backpressure: slot full blocks requests, data holds
        @(posedge clk);
        #1 id_ready = 1'b0;
        exp_q.push_back(32'hC);
        grant("t2_a12", 32'hC, 0);
        repeat (2) @(negedge clk);
        check("t2_valid", {31'b0, id_valid}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_req_blocked", {31'b0, imem_req}, 32'h0);
            check("t2_pc_hold", id_pc, 32'hC);
            check("t2_instr_hold", id_instr, 32'hC ^ DATA_KEY);
        end
        @(posedge clk);
        #1 id_ready = 1'b1;
        @(negedge clk);
        check("t2_req_on_ready", {31'b0, imem_req}, 32'h1);

        // Redirect in WAIT_RSP with the response arriving the same cycle
        grant("t3_a16", 32'h10, 0);
        pulse_redirect(32'h0000_1003);
        @(negedge clk);
        check("t3_valid", {31'b0, id_valid}, 32'h0);
        check("t3_req", {31'b0, imem_req}, 32'h1);
        check("t3_addr", imem_addr, 32'h0000_1000);

        // Redirect in WAIT_RSP before a 2-cycle response: it must be discarded later
        lat_a = 2;
        grant("t3_a1000", 32'h1000, 0);
        pulse_redirect(32'h0000_2000);
        @(negedge clk);
        check("t3_disc_req", {31'b0, imem_req}, 32'h0);
        @(negedge clk);
        check("t3_disc_valid", {31'b0, id_valid}, 32'h0);
        check("t3_disc_req2", {31'b0, imem_req}, 32'h1);
        check("t3_disc_addr", imem_addr, 32'h0000_2000);
        lat_a = 1;
        exp_q.push_back(32'h2000);
        grant("t3_a2000", 32'h2000, 0);

        // Redirect in ISSUE without grant, then redirect together with the grant for 8
        wait_req("t4_a2004", 32'h2004, 2);
        pulse_redirect(32'h0000_0004);
        exp_q.push_back(32'h4);
        grant("t4_a4", 32'h4, 1);
        wait_req("t4_a8", 32'h8, 2);
        imem_gnt       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        @(posedge clk);
        #1;
        imem_gnt       = 1'b0;
        redirect_valid = 1'b0;
        exp_q.push_back(32'h3000); exp_q.push_back(32'h3004);
        grant("t4_a3000", 32'h3000, 2);
        grant("t4_a3004", 32'h3004, 2);
        repeat (3) @(negedge clk);
        check("t4_drain", 32'(exp_q.size()), 32'h0);

        // Asynchronous reset while a response is outstanding
        lat_a = 2;
        grant("t5_a3008", 32'h3008, 1);
        rst = 1'b0;
        #1;
        check("t5_req", {31'b0, imem_req}, 32'h0);
        check("t5_addr", imem_addr, 32'h0);
        check("t5_valid", {31'b0, id_valid}, 32'h0);
        check("t5_pc", id_pc, 32'h0);
        check("t5_instr", id_instr, 32'h0);
        check("t5_b_addr", b_addr, 32'hFFFF_FFF8);
        repeat (3) @(negedge clk);
        lat_a = 1;
        exp_q.push_back(32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        grant("t5_a0", 32'h0, 1);
        repeat (3) @(negedge clk);
        check("t5_drain", 32'(exp_q.size()), 32'h0);
        check("b_drain", 32'(exp_qb.size()), 32'h0);
        check("b_grants", 32'(b_cnt), 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
